// File: rtl/bram_to_rgb.sv
// bram_to_rgb: frame-buffer read-out engine. Fetches the R, G and B bytes of each
// pixel through a 1-cycle registered-read BRAM port and streams assembled pixels.
module bram_to_rgb #(
    parameter int NUM_PIXELS = 128,
    parameter int ADDR_W     = 9,
    parameter int PIX_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base,
    output logic              bram_rd,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [7:0]        bram_data,
    output logic [7:0]        rgb_r,
    output logic [7:0]        rgb_g,
    output logic [7:0]        rgb_b,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy,
    output logic              frame_done
);

    // Pixel stream: a pixel transfers on a rising clk edge where pix_valid and
    // pix_ready are both 1; while pix_valid=1 and pix_ready=0, pix_valid, rgb_*
    // and pix_last hold; pix_ready is ignored whenever pix_valid=0.

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_R = 3'd1,
        ST_RD_G = 3'd2,
        ST_RD_B = 3'd3,
        ST_CAP  = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        rgb_r_q, rgb_r_d;
    logic [7:0]        rgb_g_q, rgb_g_d;
    logic [7:0]        rgb_b_q, rgb_b_d;
    logic              frame_done_q, frame_done_d;

    logic              is_last;
    logic [ADDR_W-1:0] pix_ext;
    logic [ADDR_W-1:0] pix_addr;

    // Byte address of the R byte of the current pixel: base + p + 2p, wrapping.
    always_comb begin
        is_last  = (pix_q == LAST_PIX);
        pix_ext  = ADDR_W'(pix_q);
        pix_addr = base_q + pix_ext + (pix_ext << 1);
    end

    // Read data lags its address by one cycle, so each byte is captured on the
    // edge leaving the state after the one that issued its address.
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        base_d       = base_q;
        rgb_r_d      = rgb_r_q;
        rgb_g_d      = rgb_g_q;
        rgb_b_d      = rgb_b_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = frame_base;
                    pix_d   = '0;
                    state_d = ST_RD_R;
                end
            end
            ST_RD_R: state_d = ST_RD_G;
            ST_RD_G: begin
                rgb_r_d = bram_data;
                state_d = ST_RD_B;
            end
            ST_RD_B: begin
                rgb_g_d = bram_data;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                rgb_b_d = bram_data;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (pix_ready) begin
                    if (is_last) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        pix_d   = pix_q + 1'b1;
                        state_d = ST_RD_R;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read port is decoded from registered state only; address parks at 0.
    always_comb begin
        bram_rd   = 1'b0;
        bram_addr = '0;
        case (state_q)
            ST_RD_R: begin
                bram_rd   = 1'b1;
                bram_addr = pix_addr;
            end
            ST_RD_G: begin
                bram_rd   = 1'b1;
                bram_addr = pix_addr + ADDR_W'(1);
            end
            ST_RD_B: begin
                bram_rd   = 1'b1;
                bram_addr = pix_addr + ADDR_W'(2);
            end
            default: begin
                bram_rd   = 1'b0;
                bram_addr = '0;
            end
        endcase
    end

    always_comb begin
        pix_valid  = (state_q == ST_OUT);
        pix_last   = (state_q == ST_OUT) && is_last;
        busy       = (state_q != ST_IDLE);
        frame_done = frame_done_q;
        rgb_r      = rgb_r_q;
        rgb_g      = rgb_g_q;
        rgb_b      = rgb_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pix_q        <= '0;
            base_q       <= '0;
            rgb_r_q      <= '0;
            rgb_g_q      <= '0;
            rgb_b_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            base_q       <= base_d;
            rgb_r_q      <= rgb_r_d;
            rgb_g_q      <= rgb_g_d;
            rgb_b_q      <= rgb_b_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_bram_to_rgb.sv
// Directed bench for bram_to_rgb: full frame, back-pressure, base wrap, start while
// busy, mid-frame reset, start on the last handshake and a one-pixel frame.
`timescale 1ns/1ps
module tb_bram_to_rgb;
    localparam int NP = 128;
    localparam int AW = 9;
    localparam int PW = 7;

    logic          clk = 1'b0;
    logic          rst, start, pix_ready;
    logic [AW-1:0] frame_base, bram_addr;
    logic          bram_rd, pix_valid, pix_last, busy, frame_done;
    logic [7:0]    bram_data = 8'h00;
    logic [7:0]    rgb_r, rgb_g, rgb_b;

    logic          start1, ready1, bram_rd1, pix_valid1, pix_last1, busy1, frame_done1;
    logic [AW-1:0] frame_base1, bram_addr1;
    logic [7:0]    bram_data1 = 8'h00;
    logic [7:0]    rgb_r1, rgb_g1, rgb_b1;

    logic [7:0]    mem [0:(1<<AW)-1];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = a[7:0];
    end

    // Registered-read BRAM models: data appears the cycle after the address.
    always @(posedge clk) begin
        if (bram_rd) bram_data <= mem[bram_addr];
        if (bram_rd1) bram_data1 <= mem[bram_addr1];
    end

    bram_to_rgb #(.NUM_PIXELS(NP), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
        .bram_rd(bram_rd), .bram_addr(bram_addr), .bram_data(bram_data),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done)
    );

    bram_to_rgb #(.NUM_PIXELS(1), .ADDR_W(AW), .PIX_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .frame_base(frame_base1),
        .bram_rd(bram_rd1), .bram_addr(bram_addr1), .bram_data(bram_data1),
        .rgb_r(rgb_r1), .rgb_g(rgb_g1), .rgb_b(rgb_b1),
        .pix_valid(pix_valid1), .pix_ready(ready1), .pix_last(pix_last1),
        .busy(busy1), .frame_done(frame_done1)
    );

    function automatic logic [7:0] exp_byte(int base, int idx, int k);
        int a;
        a = (base + 3 * idx + k) % (1 << AW);
        return a[7:0];
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic pulse_start(input logic [AW-1:0] base);
        frame_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0; frame_base = '0;
        start1 = 1'b0; ready1 = 1'b1; frame_base1 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bram_rd, bram_addr, pix_valid, pix_last, busy, frame_done} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: rd=%b addr=%0d valid=%b last=%b busy=%b done=%b, required all 0",
                     bram_rd, bram_addr, pix_valid, pix_last, busy, frame_done);
        end
        n_cmp++;
        if ({rgb_r, rgb_g, rgb_b} !== 24'd0) begin
            n_bad++;
            $display("FAIL reset_rgb: got %h required 000000", {rgb_r, rgb_g, rgb_b});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || bram_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b rd=%b, required 0 0", busy, bram_rd);
        end
    endtask

    task automatic test_full_frame();
        int idx, ndone, done_cyc, first_valid;
        idx = 0; ndone = 0; done_cyc = -1; first_valid = -1;
        pix_ready = 1'b1;
        pulse_start(9'd0);
        for (int c = 1; c <= 645; c++) begin
            if (c == 1) begin
                n_cmp++;
                if (busy !== 1'b1 || bram_rd !== 1'b1 || bram_addr !== 9'd0) begin
                    n_bad++;
                    $display("FAIL full_cycle1: busy=%b rd=%b addr=%0d, required 1 1 0", busy, bram_rd, bram_addr);
                end
            end
            if (c == 641) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_busy_641: busy=%b required 0", busy);
                end
            end
            if (bram_rd === 1'b0) begin
                n_cmp++;
                if (bram_addr !== 9'd0) begin
                    n_bad++;
                    $display("FAIL full_addr_idle: cycle %0d addr=%0d required 0", c, bram_addr);
                end
            end
            if (frame_done === 1'b1) begin
                ndone++;
                done_cyc = c;
            end
            if (pix_valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                n_cmp++;
                if (rgb_r !== exp_byte(0, idx, 0) || rgb_g !== exp_byte(0, idx, 1) || rgb_b !== exp_byte(0, idx, 2)) begin
                    n_bad++;
                    $display("FAIL full_pixel %0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", idx, rgb_r, rgb_g, rgb_b,
                             exp_byte(0, idx, 0), exp_byte(0, idx, 1), exp_byte(0, idx, 2));
                end
                n_cmp++;
                if (pix_last !== (idx == NP - 1)) begin
                    n_bad++;
                    $display("FAIL full_last %0d: got %b required %b", idx, pix_last, (idx == NP - 1));
                end
                idx++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (idx != NP) begin
            n_bad++;
            $display("FAIL full_count: got %0d pixels required %0d", idx, NP);
        end
        n_cmp++;
        if (ndone != 1 || done_cyc != 641) begin
            n_bad++;
            $display("FAIL full_done: got %0d pulses at cycle %0d, required 1 at 641", ndone, done_cyc);
        end
        n_cmp++;
        if (first_valid != 5) begin
            n_bad++;
            $display("FAIL full_latency: first valid in cycle %0d required 5", first_valid);
        end
    endtask

    task automatic test_back_pressure();
        int idx, stall;
        idx = 0; stall = 0;
        pix_ready = 1'b1;
        pulse_start(9'd0);
        for (int c = 1; c <= 120 && idx < 6; c++) begin
            if (idx == 4 && stall < 7 && (pix_valid === 1'b1 || stall > 0)) begin
                pix_ready = 1'b0;
                stall++;
                n_cmp++;
                if (pix_valid !== 1'b1 || rgb_r !== 8'd12 || rgb_g !== 8'd13 || rgb_b !== 8'd14) begin
                    n_bad++;
                    $display("FAIL bp_hold: stall %0d valid=%b rgb=(%0d,%0d,%0d) required 1 (12,13,14)",
                             stall, pix_valid, rgb_r, rgb_g, rgb_b);
                end
                n_cmp++;
                if (bram_rd !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_no_read: stall %0d rd=%b required 0", stall, bram_rd);
                end
            end else begin
                pix_ready = 1'b1;
                if (pix_valid === 1'b1) begin
                    n_cmp++;
                    if (rgb_r !== exp_byte(0, idx, 0) || rgb_g !== exp_byte(0, idx, 1) || rgb_b !== exp_byte(0, idx, 2)) begin
                        n_bad++;
                        $display("FAIL bp_pixel %0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", idx, rgb_r, rgb_g, rgb_b,
                                 exp_byte(0, idx, 0), exp_byte(0, idx, 1), exp_byte(0, idx, 2));
                    end
                    idx++;
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (stall != 7 || idx != 6) begin
            n_bad++;
            $display("FAIL bp_progress: stalls=%0d pixels=%0d required 7 6", stall, idx);
        end
        pix_ready = 1'b1;
        do_reset();
    endtask

    task automatic test_base_wrap();
        logic [AW-1:0] addr_q[$];
        logic [AW-1:0] exp_addr [6];
        logic [23:0]   exp_pix [2];
        int idx;
        exp_addr = '{9'd510, 9'd511, 9'd0, 9'd1, 9'd2, 9'd3};
        exp_pix  = '{{8'd254, 8'd255, 8'd0}, {8'd1, 8'd2, 8'd3}};
        idx = 0;
        pix_ready = 1'b1;
        pulse_start(9'd510);
        for (int c = 1; c <= 10; c++) begin
            if (bram_rd === 1'b1) addr_q.push_back(bram_addr);
            if (pix_valid === 1'b1 && idx < 2) begin
                n_cmp++;
                if ({rgb_r, rgb_g, rgb_b} !== exp_pix[idx]) begin
                    n_bad++;
                    $display("FAIL wrap_pixel %0d: got %h required %h", idx, {rgb_r, rgb_g, rgb_b}, exp_pix[idx]);
                end
                idx++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (addr_q.size() != 6) begin
            n_bad++;
            $display("FAIL wrap_reads: got %0d reads required 6", addr_q.size());
        end
        for (int i = 0; i < 6 && i < addr_q.size(); i++) begin
            n_cmp++;
            if (addr_q[i] !== exp_addr[i]) begin
                n_bad++;
                $display("FAIL wrap_addr %0d: got %0d required %0d", i, addr_q[i], exp_addr[i]);
            end
        end
        do_reset();
    endtask

    task automatic test_start_busy();
        int idx, ndone;
        idx = 0; ndone = 0;
        pix_ready = 1'b1;
        pulse_start(9'd0);
        for (int c = 1; c <= 650; c++) begin
            if (c == 20) begin
                start = 1'b1;
                frame_base = 9'd100;
            end else begin
                start = 1'b0;
                frame_base = 9'd0;
            end
            if (c == 21) begin
                n_cmp++;
                if (bram_rd !== 1'b1 || bram_addr !== 9'd12) begin
                    n_bad++;
                    $display("FAIL busy_addr: rd=%b addr=%0d required 1 12", bram_rd, bram_addr);
                end
            end
            if (frame_done === 1'b1) ndone++;
            if (pix_valid === 1'b1) begin
                n_cmp++;
                if (rgb_r !== exp_byte(0, idx, 0) || rgb_g !== exp_byte(0, idx, 1) || rgb_b !== exp_byte(0, idx, 2)) begin
                    n_bad++;
                    $display("FAIL busy_pixel %0d: got (%0d,%0d,%0d)", idx, rgb_r, rgb_g, rgb_b);
                end
                idx++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (idx != NP || ndone != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_frame: pixels=%0d done=%0d busy=%b required %0d 1 0", idx, ndone, busy, NP);
        end
    endtask

    task automatic test_reset_mid();
        int idx, ndone, first;
        logic found;
        idx = 0; ndone = 0; first = -1; found = 1'b0;
        pix_ready = 1'b1;
        pulse_start(9'd0);
        for (int c = 1; c <= 100 && !found; c++) begin
            if (pix_valid === 1'b1 && idx == 10) begin
                found = 1'b1;
                rst = 1'b1;
            end else if (pix_valid === 1'b1) begin
                idx++;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        n_cmp++;
        if (!found || {bram_rd, bram_addr, pix_valid, pix_last, busy, frame_done, rgb_r, rgb_g, rgb_b} !== 38'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: found=%b busy=%b valid=%b rd=%b rgb=%h, required all 0",
                     found, busy, pix_valid, bram_rd, {rgb_r, rgb_g, rgb_b});
        end
        for (int c = 0; c < 3; c++) begin
            if (frame_done === 1'b1 || busy === 1'b1) ndone++;
            @(negedge clk);
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: got %0d done/busy cycles required 0", ndone);
        end
        pulse_start(9'd0);
        for (int c = 1; c <= 8; c++) begin
            if (pix_valid === 1'b1 && first < 0) begin
                first = c;
                n_cmp++;
                if ({rgb_r, rgb_g, rgb_b} !== 24'h000102 || pix_last !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rstmid_pixel0: got %h last=%b required 000102 0", {rgb_r, rgb_g, rgb_b}, pix_last);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (first != 5) begin
            n_bad++;
            $display("FAIL rstmid_latency: first valid in cycle %0d required 5", first);
        end
        do_reset();
    endtask

    task automatic test_start_last();
        int ndone, nbusy;
        ndone = 0; nbusy = 0;
        pix_ready = 1'b1;
        pulse_start(9'd0);
        for (int c = 1; c <= 640; c++) begin
            if (c == 640) begin
                n_cmp++;
                if (pix_valid !== 1'b1 || pix_last !== 1'b1) begin
                    n_bad++;
                    $display("FAIL last_out: valid=%b last=%b required 1 1", pix_valid, pix_last);
                end
                start = 1'b1;
                frame_base = 9'd33;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL last_done: done=%b busy=%b required 1 0", frame_done, busy);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) ndone++;
            if (busy === 1'b1) nbusy++;
        end
        n_cmp++;
        if (ndone != 0 || nbusy != 0) begin
            n_bad++;
            $display("FAIL last_ignored: extra done=%0d busy cycles=%0d required 0 0", ndone, nbusy);
        end
        pulse_start(9'd33);
        n_cmp++;
        if (busy !== 1'b1 || bram_addr !== 9'd33) begin
            n_bad++;
            $display("FAIL last_restart: busy=%b addr=%0d required 1 33", busy, bram_addr);
        end
        do_reset();
    endtask

    task automatic test_single_pixel();
        frame_base1 = 9'd3;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) begin
                n_cmp++;
                if (pix_valid1 !== 1'b1 || pix_last1 !== 1'b1 || {rgb_r1, rgb_g1, rgb_b1} !== 24'h030405) begin
                    n_bad++;
                    $display("FAIL single_pixel: valid=%b last=%b rgb=%h required 1 1 030405",
                             pix_valid1, pix_last1, {rgb_r1, rgb_g1, rgb_b1});
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (frame_done1 !== 1'b1 || busy1 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_done: done=%b busy=%b required 1 0", frame_done1, busy1);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_back_pressure();
        test_base_wrap();
        test_start_busy();
        test_reset_mid();
        test_start_last();
        test_single_pixel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
